imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Successor to the single-cycle immediate extender, for the pipelined core.
//  Accepts 32-bit RV instructions with their PC over a valid/ready handshake.
//  Extracts the immediate and sign-extends it to XLEN, either from an external
//  ImmSrc or by decoding the opcode itself. Also computes the branch/jump target
//  PC+imm. Results are buffered in a DEPTH-entry FIFO that feeds the execute stage.
// PARAMETERS
//  XLEN         32  datapath width; legal values are 32 and 64
//  DEPTH        2   result FIFO entries; >=1, need not be a power of 2
//  AUTO_DECODE  1   1: ImmSrc from opcode; 0: ImmSrc from in_imm_src port
// PORTS
//  clk           in   1     clock; all state updates on the rising edge
//  reset         in   1     synchronous, active-high
//  flush         in   1     discard all buffered entries and this cycle's input
//  in_valid      in   1     in_instr/in_pc/in_imm_src are valid
//  in_ready      out  1     block can accept an input this cycle
//  in_instr      in   32    instruction word
//  in_pc         in   XLEN  PC of in_instr
//  in_imm_src    in   3     external ImmSrc; ignored when AUTO_DECODE=1
//  out_valid     out  1     head FIFO entry is valid
//  out_ready     in   1     consumer takes the head entry
//  out_imm       out  XLEN  extended immediate
//  out_target    out  XLEN  out_pc + out_imm, mod 2^XLEN
//  out_pc        out  XLEN  PC carried with the entry
//  out_imm_src   out  3     ImmSrc that was used
//  out_illegal   out  1     ImmSrc or opcode not recognised
// BEHAVIOUR
//  ImmSrc encoding:
//   000 I: {sext instr[31:20]}
//   001 S: {sext instr[31:25], instr[11:7]}
//   010 B: {sext instr[31], instr[7], instr[30:25], instr[11:8], 0}
//   011 J: {sext instr[31], instr[19:12], instr[20], instr[30:21], 0}
//   100 U: {sext instr[31:12], 12'b0}; sext only matters when XLEN=64
//   101-111: illegal; imm=0, out_illegal=1
//  Opcode map when AUTO_DECODE=1:
//   0010011, 0000011, 1100111, 1110011 -> I
//   0100011 -> S;  1100011 -> B;  1101111 -> J;  0110111, 0010111 -> U
//   any other opcode -> illegal, imm_src=111
//  All sign extension copies instr[31] up to bit XLEN-1.
//  Handshake: accept when in_valid&&in_ready; pop when out_valid&&out_ready.
//  in_ready = (count<DEPTH). It is not combinationally tied to out_ready, so a
//   full FIFO takes no input, even in a cycle where it pops.
//  Latency: an entry accepted at edge N is visible at out_* after edge N
//   (1 cycle). Outputs are driven straight from FIFO storage, not from logic.
//  Simultaneous push and pop when not full: count is unchanged; order is kept.
//  Pointers wrap from DEPTH-1 to 0. count width is $clog2(DEPTH+1).
//  flush: next state is empty and the same-cycle input is dropped.
//   Flush has priority over push and pop.
//  reset: same effect as flush, and overrides it. Applies mid-stream with no
//   partial entries. Reset values:
//   out_valid=0, in_ready=1, out_imm/out_target/out_pc=0, out_imm_src=0,
//   out_illegal=0, count=0, pointers=0.
//  out_* are don't-care while out_valid=0. The TB checks them only when
//   out_valid=1, apart from the reset values above.
// STRUCTURE
//  Package riscv_imm_pkg holds:
//   IMM_I/S/B/J/U/ILL localparams (3-bit)
//   OPC_* 7-bit opcode constants
//   function imm_src_from_opcode
//  Sub-module imm_decode_core (combinational): instr, imm_src -> imm, illegal;
//   parametrised by XLEN.
//  Top level holds the ImmSrc mux, the PC+imm adder, the FIFO and the control.
// TESTING (XLEN=32, DEPTH=2, AUTO_DECODE=1 unless noted)
//  1 0xFFF00093 (addi x1,x0,-1), pc=0x100 -> out_imm=0xFFFFFFFF,
//    out_target=0xFF, out_imm_src=000, illegal=0, one cycle later.
//  2 0x00112623 -> imm=0x0000000C, src=001.
//    0xFE000EE3 @pc 0x200 -> imm=0xFFFFFFFC, target=0x1FC.
//    0x0080006F -> imm=8.  0x123452B7 -> imm=0x12345000.
//  3 out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts,
//    3rd held. Release out_ready -> three pops in order, no loss.
//  4 FIFO full, assert flush together with in_valid -> next cycle
//    out_valid=0, in_ready=1, flushed input never appears.
//  5 opcode 0000000, and AUTO_DECODE=0 with in_imm_src=110
//    -> out_illegal=1, out_imm=0.
//  6 XLEN=64: 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000.
//    Reset mid-stream with 2 entries buffered -> all reset values above
//    one cycle later.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// Shared ImmSrc codes, RV32/64 opcode constants and the opcode-to-ImmSrc decode
// used by the pipelined immediate extender.
package riscv_imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_ILL = 3'b111;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic [2:0] imm_src_from_opcode(input logic [6:0] opc);
    logic [2:0] src;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: src = IMM_I;
      OPC_STORE:                                  src = IMM_S;
      OPC_BRANCH:                                 src = IMM_B;
      OPC_JAL:                                    src = IMM_J;
      OPC_LUI, OPC_AUIPC:                         src = IMM_U;
      default:                                    src = IMM_ILL;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/imm_decode_core.sv
// Combinational immediate extraction: picks the instruction fields for the
// given ImmSrc and sign-extends the result from bit 31 to XLEN.
module imm_decode_core
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]             instr,
  input  logic [2:0]              imm_src,
  output logic signed [XLEN-1:0]  imm,
  output logic                    illegal
);

  logic signed [31:0] imm32;

  // A signed size cast replicates bit 31 into the upper half when XLEN=64.
  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'h000};
      default: illegal = 1'b1;
    endcase
  end

  assign imm = sext_xlen(imm32);

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: decodes the immediate and PC+imm target of each
// accepted instruction and queues the results in a DEPTH-entry FIFO.
module imm_ext_pipe
  import riscv_imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_imm_src,
  output logic            out_illegal
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic                   vld_p0;
  logic                   pop;
  logic [2:0]             imm_src_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   illegal_p0;
  logic [XLEN-1:0]        target_p0;

  logic [XLEN-1:0] imm_mem_p1    [DEPTH];
  logic [XLEN-1:0] target_mem_p1 [DEPTH];
  logic [XLEN-1:0] pc_mem_p1     [DEPTH];
  logic [2:0]      src_mem_p1    [DEPTH];
  logic            ill_mem_p1    [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign vld_p0    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // ---- p0: ImmSrc select, extraction and target add
  assign imm_src_p0 = AUTO_DECODE ? imm_src_from_opcode(in_instr[6:0]) : in_imm_src;

  imm_decode_core #(.XLEN(XLEN)) u_core (
    .instr   (in_instr[31:7]),
    .imm_src (imm_src_p0),
    .imm     (imm_p0),
    .illegal (illegal_p0)
  );

  assign target_p0 = in_pc + $unsigned(imm_p0);

  // ---- p1: FIFO control; flush empties the queue, reset additionally overrides it
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vld_p0) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({vld_p0, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head entry reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_p1[i]    <= '0;
        target_mem_p1[i] <= '0;
        pc_mem_p1[i]     <= '0;
        src_mem_p1[i]    <= '0;
        ill_mem_p1[i]    <= 1'b0;
      end
    end else if (vld_p0 && !flush) begin
      imm_mem_p1[wr_ptr]    <= $unsigned(imm_p0);
      target_mem_p1[wr_ptr] <= target_p0;
      pc_mem_p1[wr_ptr]     <= in_pc;
      src_mem_p1[wr_ptr]    <= imm_src_p0;
      ill_mem_p1[wr_ptr]    <= illegal_p0;
    end
  end

  assign out_imm     = imm_mem_p1[rd_ptr];
  assign out_target  = target_mem_p1[rd_ptr];
  assign out_pc      = pc_mem_p1[rd_ptr];
  assign out_imm_src = src_mem_p1[rd_ptr];
  assign out_illegal = ill_mem_p1[rd_ptr];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: scoreboarded main instance (XLEN=32, auto decode)
// plus an external-ImmSrc instance and an XLEN=64 instance for directed steps.
module tb_imm_ext_pipe;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [2:0]  src;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target, out_pc;
  logic [2:0]  in_imm_src, out_imm_src;

  logic        e_in_valid, e_in_ready, e_out_valid, e_out_illegal;
  logic [31:0] e_out_imm, e_out_target, e_out_pc;
  logic [2:0]  e_out_imm_src;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_illegal;
  logic [63:0] w_in_pc, w_out_imm, w_out_target, w_out_pc;
  logic [2:0]  w_out_imm_src;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_imm_src(in_imm_src), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
    .out_imm_src(out_imm_src), .out_illegal(out_illegal)
  );

  imm_ext_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1'b0)) dut_ext (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_imm_src(in_imm_src), .out_valid(e_out_valid),
    .out_ready(1'b1), .out_imm(e_out_imm), .out_target(e_out_target), .out_pc(e_out_pc),
    .out_imm_src(e_out_imm_src), .out_illegal(e_out_illegal)
  );

  imm_ext_pipe #(.XLEN(64), .DEPTH(2), .AUTO_DECODE(1'b1)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(w_in_pc), .in_imm_src(in_imm_src), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_imm(w_out_imm), .out_target(w_out_target), .out_pc(w_out_pc),
    .out_imm_src(w_out_imm_src), .out_illegal(w_out_illegal)
  );

  function automatic logic [2:0] model_src(input logic [6:0] opc);
    case (opc)
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
      7'h23:                      return 3'd1;
      7'h63:                      return 3'd2;
      7'h6F:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] src);
    logic signed [63:0] v;
    case (src)
      3'd0:    v = $signed(i[31:20]);
      3'd1:    v = $signed({i[31:25], i[11:7]});
      3'd2:    v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd3:    v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      3'd4:    v = $signed({i[31:12], 12'h000});
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: pushes accepted inputs, compares popped heads, drops on flush/reset.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 || flush === 1'b1) begin
      q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_assert++;
        assert (q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_out: observed entry imm %h expected none", out_imm);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_imm", 64'(out_imm), 64'(e.imm));
          chk("sb_target", 64'(out_target), 64'(e.tgt));
          chk("sb_pc", 64'(out_pc), 64'(e.pc));
          chk("sb_src", 64'(out_imm_src), 64'(e.src));
          chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        e.src = model_src(in_instr[6:0]);
        e.imm = model_imm(in_instr, e.src)[31:0];
        e.tgt = in_pc + e.imm;
        e.pc  = in_pc;
        e.ill = (e.src == 3'd7);
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives one instruction into the main instance; returns just after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
      if (n >= 3) out_ready = 1'b1;
    end
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL send_timeout: observed in_ready 0 expected 1 within 50 cycles");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() != 0; n++) step();
    step();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [6:0]  opcs [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h00, 7'h7F};
  logic [31:0] r;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_imm_src = 3'd0;
    e_in_valid = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_pc = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_target", 64'(out_target), 64'd0);
    chk("rst_out_src", 64'(out_imm_src), 64'd0);
    chk("rst_count", 64'(dut.count), 64'd0);
    step();

    // addi x1,x0,-1: visible one cycle after acceptance
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h100);
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("t1_target", 64'(out_target), 64'h000000FF);
    chk("t1_src", 64'(out_imm_src), 64'd0);
    chk("t1_illegal", 64'(out_illegal), 64'd0);
    step();

    send(32'h00112623, 32'h0);
    @(negedge clk);
    chk("t2_s_imm", 64'(out_imm), 64'h0000000C);
    chk("t2_s_src", 64'(out_imm_src), 64'd1);
    step();
    send(32'hFE000EE3, 32'h200);
    @(negedge clk);
    chk("t2_b_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("t2_b_target", 64'(out_target), 64'h000001FC);
    step();
    send(32'h0080006F, 32'h0);
    @(negedge clk);
    chk("t2_j_imm", 64'(out_imm), 64'h8);
    step();
    send(32'h123452B7, 32'h0);
    @(negedge clk);
    chk("t2_u_imm", 64'(out_imm), 64'h12345000);
    step();
    send(32'h00000000, 32'h300);
    @(negedge clk);
    chk("t5_ill", 64'(out_illegal), 64'd1);
    chk("t5_ill_imm", 64'(out_imm), 64'd0);
    chk("t5_ill_src", 64'(out_imm_src), 64'd7);
    drain();

    // backpressure: two accepted, third held until the consumer releases
    out_ready = 1'b0;
    send(32'h00100093, 32'h400);
    send(32'h00200093, 32'h404);
    in_instr = 32'h00300093; in_pc = 32'h408; in_valid = 1'b1;
    @(negedge clk);
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("t3_held_ready", 64'(in_ready), 64'd0);
    chk("t3_count", 64'(dut.count), 64'd2);
    step();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && !(in_ready === 1'b1); n++) begin
      @(negedge clk);
      if (in_ready) break;
      step();
    end
    step();
    in_valid = 1'b0;
    drain();

    // flush while full, with a same-cycle input that must be dropped
    out_ready = 1'b0;
    send(32'h00500093, 32'h500);
    send(32'h00600093, 32'h504);
    in_instr = 32'h00700093; in_pc = 32'h508; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("t4_no_ghost", 64'(out_valid), 64'd0);
    step();

    // mixed opcodes with random backpressure
    for (int k = 0; k < 16; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      r = $urandom;
      r[6:0] = opcs[$urandom_range(0, 10)];
      send(r, $urandom);
    end
    drain();

    // external ImmSrc instance
    in_imm_src = 3'b110; in_instr = 32'hFFF00093; in_pc = 32'h40; e_in_valid = 1'b1;
    step();
    e_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_ext_valid", 64'(e_out_valid), 64'd1);
    chk("t5_ext_ill", 64'(e_out_illegal), 64'd1);
    chk("t5_ext_imm", 64'(e_out_imm), 64'd0);
    chk("t5_ext_src", 64'(e_out_imm_src), 64'd6);
    step();
    in_imm_src = 3'b001; in_instr = 32'h00112623; e_in_valid = 1'b1;
    step();
    e_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_ext_s_imm", 64'(e_out_imm), 64'h0000000C);
    chk("t5_ext_s_ill", 64'(e_out_illegal), 64'd0);
    step();

    // XLEN=64 instance: lui sign extension, then reset with two entries buffered
    in_instr = 32'h800002B7; w_in_pc = 64'h1000; w_in_valid = 1'b1;
    step();
    in_instr = 32'hFFF00093; w_in_pc = 64'h2000;
    @(negedge clk);
    chk("t6_imm64", w_out_imm, 64'hFFFFFFFF80000000);
    chk("t6_target64", w_out_target, 64'hFFFFFFFF80001000);
    chk("t6_src64", 64'(w_out_imm_src), 64'd4);
    step();
    w_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_full64", 64'(w_in_ready), 64'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 64'(w_out_valid), 64'd0);
    chk("t6_rst_ready", 64'(w_in_ready), 64'd1);
    chk("t6_rst_imm", w_out_imm, 64'd0);
    chk("t6_rst_target", w_out_target, 64'd0);
    chk("t6_rst_pc", w_out_pc, 64'd0);
    chk("t6_rst_src", 64'(w_out_imm_src), 64'd0);
    chk("t6_rst_ill", 64'(w_out_illegal), 64'd0);
    chk("t6_rst_count", 64'(dut64.count), 64'd0);
    chk("t6_rst_wptr", 64'(dut64.wr_ptr), 64'd0);
    chk("t6_rst_rptr", 64'(dut64.rd_ptr), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
